// File: rtl/seven_segment_scanner_if.sv
// Bundles the scan enable, digit data and display outputs of seven_segment_scanner.
// master: the side supplying digits; slave: the scanner itself.
interface seven_segment_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [3:0]              num;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    dp;
  logic                    frame_tick;

  modport master (
    output en, digits, dp_in,
    input  num, dig_en, dp, frame_tick
  );

  modport slave (
    input  en, digits, dp_in,
    output num, dig_en, dp, frame_tick
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 7-segment scanner with a blanking guard at the start of every digit slot.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on digits above digit 0.
module seven_segment_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  seven_segment_scanner_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [3:0]            snap_q, snap_d;
  logic                  snap_dp_q, snap_dp_d;
  logic [3:0]            num_q, num_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  dp_q, dp_d;
  logic                  tick_q, tick_d;
  logic                  take;
  logic [3:0]            digit_arr [NUM_DIGITS];

  always_comb begin
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      digit_arr[i] = bus.digits[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[i]: digit i and every more-significant digit are zero
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    lead_zero = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      for (int j = 0; j < int'(NUM_DIGITS); j++) begin
        if (j >= i && digit_arr[j] != 4'd0) lead_zero[i] = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    tick_d    = 1'b0;
    take      = 1'b0;

    if (!bus.en) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = '0;
          take    = 1'b1;
        end
        StBlank: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(BLANK_CYCLES - 1)) state_d = StDrive;
        end
        StDrive: begin
          if (cnt_q == CntW'(CLK_DIV - 1)) begin
            cnt_d   = '0;
            state_d = StBlank;
            take    = 1'b1;
            if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
              idx_d  = '0;
              tick_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Sample the digit once, on the edge that enters its slot, so mid-slot changes cannot tear
    if (take) begin
      snap_d    = digit_arr[idx_d];
      snap_dp_d = bus.dp_in[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_d != '0 && lead_zero[idx_d]) snap_d = 4'hF;
`endif
    end

    num_d = (state_d == StDrive) ? snap_d : 4'hF;
    dp_d  = (state_d == StDrive) ? snap_dp_d : 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      dig_en_d[i] = (state_d == StDrive) && (idx_d == IdxW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      snap_dp_q <= 1'b0;
      num_q     <= 4'hF;
      dig_en_q  <= '0;
      dp_q      <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      num_q     <= num_d;
      dig_en_q  <= dig_en_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.num        = num_q;
  assign bus.dig_en     = dig_en_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2).
// Expected lit cycles and frame ticks are queued by cycle number; a negedge monitor checks them.
module tb_seven_segment_scanner;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seven_segment_scanner_if #(.NUM_DIGITS(4)) bus ();

  seven_segment_scanner #(
    .NUM_DIGITS  (4),
    .CLK_DIV     (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] de;
    logic [3:0] num;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   tq[$];

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: %s", name, cyc, detail);
    end
  endtask

  // Slot entered at edge 'start': two blank cycles, then up to six lit cycles
  task automatic push_slot(input int start, input int d, input logic [3:0] v, input logic p,
                           input int ncyc);
    logic [3:0] one;
    exp_t       e;
    one = 4'b0001;
    for (int k = 0; k < ncyc; k++) begin
      e.cyc = start + 2 + k;
      e.de  = one << d;
      e.num = v;
      e.dp  = p;
      q.push_back(e);
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      check(1'b0, "missing_drive",
            $sformatf("no lit output at cyc %0d, required dig_en=%b num=%h", q[0].cyc, q[0].de,
                      q[0].num));
      void'(q.pop_front());
    end
    while (tq.size() > 0 && tq[0] < cyc) begin
      check(1'b0, "missing_tick", $sformatf("frame_tick absent, required at cyc %0d", tq[0]));
      void'(tq.pop_front());
    end
    check($onehot0(bus.dig_en), "onehot", $sformatf("dig_en=%b", bus.dig_en));
    if (bus.dig_en != 4'b0000) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        check(1'b0, "unexpected_drive",
              $sformatf("got dig_en=%b num=%h, required blank", bus.dig_en, bus.num));
      end else begin
        e = q.pop_front();
        check(bus.dig_en == e.de && bus.num == e.num && bus.dp == e.dp, "drive",
              $sformatf("got dig_en=%b num=%h dp=%b, required dig_en=%b num=%h dp=%b",
                        bus.dig_en, bus.num, bus.dp, e.de, e.num, e.dp));
      end
    end else begin
      check(bus.num == 4'hF && bus.dp == 1'b0, "blank_out",
            $sformatf("got num=%h dp=%b, required num=f dp=0", bus.num, bus.dp));
    end
    if (bus.frame_tick) begin
      if (tq.size() == 0 || tq[0] != cyc) begin
        check(1'b0, "unexpected_tick", "got frame_tick=1, required 0");
      end else begin
        check(1'b1, "tick", "");
        void'(tq.pop_front());
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.digits = 16'h0000;
    bus.dp_in  = 4'b0000;

    // Reset held 20 cycles, then idle with en low
    wait_edge(20);
    check(bus.num == 4'hF && bus.dig_en == 4'b0000 && bus.dp == 1'b0 && !bus.frame_tick,
          "reset_state", $sformatf("got num=%h dig_en=%b dp=%b tick=%b, required f 0000 0 0",
                                   bus.num, bus.dig_en, bus.dp, bus.frame_tick));
    rst_n = 1'b1;

    // Scan order, snapshot stability, en drop: scan starts at edge 31
    wait_edge(30);
    bus.digits = 16'h4321;
    bus.dp_in  = 4'b0010;
    bus.en     = 1'b1;
    for (int k = 0; k < 4; k++) push_slot(31 + 8*k, k, 4'(k + 1), k == 1, 6);
    push_slot(63, 0, 4'h1, 1'b0, 6);
    push_slot(71, 1, 4'h2, 1'b1, 6);
    push_slot(79, 2, 4'h3, 1'b0, 6);
    push_slot(87, 3, 4'h9, 1'b0, 6);
    push_slot(95, 0, 4'h9, 1'b0, 6);
    push_slot(103, 1, 4'h9, 1'b1, 3);
    tq.push_back(63);
    tq.push_back(95);

    wait_edge(82);
    bus.digits = 16'h9999;

    wait_edge(107);
    bus.en = 1'b0;
    wait_edge(108);
    check(bus.num == 4'hF && bus.dig_en == 4'b0000, "en_drop",
          $sformatf("got num=%h dig_en=%b, required f 0000", bus.num, bus.dig_en));

    wait_edge(112);
    bus.en = 1'b1;
    push_slot(113, 0, 4'h9, 1'b0, 4);

    // Asynchronous reset in the middle of a lit cycle
    wait_edge(119);
    #1;
    rst_n = 1'b0;
    #1;
    check(bus.num == 4'hF && bus.dig_en == 4'b0000 && bus.dp == 1'b0, "async_reset",
          $sformatf("got num=%h dig_en=%b dp=%b, required f 0000 0", bus.num, bus.dig_en,
                    bus.dp));
    bus.en = 1'b0;
    wait_edge(124);
    rst_n = 1'b1;

    // Leading-zero handling, one full frame from edge 131
    wait_edge(130);
    bus.digits = 16'h0070;
    bus.dp_in  = 4'b0000;
    bus.en     = 1'b1;
    push_slot(131, 0, 4'h0, 1'b0, 6);
    push_slot(139, 1, 4'h7, 1'b0, 6);
`ifdef LEADING_ZERO_BLANK_EN
    push_slot(147, 2, 4'hF, 1'b0, 6);
    push_slot(155, 3, 4'hF, 1'b0, 6);
`else
    push_slot(147, 2, 4'h0, 1'b0, 6);
    push_slot(155, 3, 4'h0, 1'b0, 6);
`endif
    tq.push_back(163);
    wait_edge(163);
    bus.en = 1'b0;

    wait_edge(175);
    check(q.size() == 0, "drive_queue_empty", $sformatf("%0d entries left, required 0", q.size()));
    check(tq.size() == 0, "tick_queue_empty", $sformatf("%0d entries left, required 0", tq.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Time-multiplexed driver for a common-select multi-digit 7-segment display.
- Sits directly upstream of the BCD-to-segment decoder and drives its 4-bit `num` input. It also drives the per-digit select lines and the decimal point.
- Cycles through NUM_DIGITS slots with a programmable dwell time.
- Inserts a blanking guard at the start of every slot to suppress ghosting.

Parameters:
- NUM_DIGITS, 4, number of display digits; legal range 1..8.
- CLK_DIV, 50000, clk cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits deselected; must be 1 or more.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable; low forces the display blank and idle.
- digits  input  4*NUM_DIGITS  BCD digit values; digit i is digits[4*i+3:4*i], digit 0 is least significant.
- dp_in  input  NUM_DIGITS  decimal point request per digit.
- num  output  4  BCD code to the segment decoder; 4'hF means blank.
- dig_en  output  NUM_DIGITS  one-hot active-high digit select; all-zero means no digit is lit.
- dp  output  1  decimal point for the currently selected digit.
- frame_tick  output  1  one-cycle pulse when a full scan of all digits completes.

Behaviour:
- Reset is asynchronous and active-low and uses port rst_n. Everything else is synchronous to rising clk.
- Reset values: num=4'hF, dig_en=0, dp=0, frame_tick=0, state=IDLE, idx=0, cnt=0.
- All outputs are registered.
- Internal state:
  - slot counter cnt, range 0..CLK_DIV-1.
  - digit index idx, range 0..NUM_DIGITS-1.
  - snapshot register snap[3:0] and snap_dp.
- State machine, three states:
  - IDLE: outputs blank (num=F, dig_en=0, dp=0). When en=1, go to BLANK on the next edge with cnt=0 and idx=0, and capture snapshot of digit 0.
  - BLANK: active while cnt < BLANK_CYCLES. Outputs num=F, dig_en=0, dp=0. When cnt reaches BLANK_CYCLES-1, go to DRIVE.
  - DRIVE: outputs num=snap, dig_en=(1<<idx), dp=snap_dp. At cnt==CLK_DIV-1:
    - cnt wraps to 0.
    - idx advances, wrapping from NUM_DIGITS-1 to 0.
    - state goes to BLANK.
    - The snapshot of the new idx is captured on the same edge.
- Snapshot timing: the digit value and dp are sampled once per slot, on the edge that enters the slot. Changes to `digits` or dp_in during a slot are not shown until that digit's next slot, so no tearing occurs.
- Slot length is exactly CLK_DIV cycles: BLANK_CYCLES blank cycles followed by CLK_DIV-BLANK_CYCLES drive cycles.
- frame_tick is high for exactly one cycle, coincident with the first BLANK cycle after idx wraps to 0. It is not asserted on the initial IDLE-to-BLANK entry.
- en deasserted in any state: on the next edge, state=IDLE, cnt=0, idx=0, and outputs are blank. No partial-slot completion.
- en reasserted: scan restarts at digit 0 with a full blank guard.
- NUM_DIGITS=1: idx stays at 0 and frame_tick pulses once per slot, after the first slot.
- Snapshot BCD values 10..14 are passed to num unchanged; the decoder blanks them.
- dig_en never has more than one bit set.
- dig_en is never nonzero in the same cycle that num changes value.
- Reset asserted mid-scan: all outputs go to their reset values immediately, asynchronously.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when a snapshot is taken, a digit i>0 is replaced by 4'hF if it and all more-significant digits are 0. Its dp is still honoured. Digit 0 is always shown.
- Undefined: all digits are shown as-is, including leading zeros.

Test Plan:
- Reset and idle (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, en=0): hold 20 cycles, release rst_n -> num=F, dig_en=0000, frame_tick never set.
- Scan order (digits=16'h4321, dp_in=0010, en=1): each 8-cycle slot has 2 cycles of dig_en=0000 and num=F, then 6 cycles of the pattern below. frame_tick pulses every 32 cycles after the first frame.
  - dig_en=0001, num=1
  - dig_en=0010, num=2, dp=1
  - dig_en=0100, num=3
  - dig_en=1000, num=4
- Snapshot stability: change digits to 16'h9999 at the 4th cycle of the digit-2 slot -> num stays 3 for the rest of that slot, and the digit-3 slot shows 9.
- en drop mid-DRIVE on digit 1: one edge later num=F and dig_en=0000. Raise en 5 cycles later -> 2 blank cycles, then dig_en=0001.
- Async reset: assert rst_n=0 between clock edges during DRIVE -> dig_en=0000 and num=F before the next edge.
- LEADING_ZERO_BLANK_EN defined, digits=16'h0070: slot outputs are, in order, num=0, 7, F, F. With the macro undefined they are 0, 7, 0, 0.
